// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART defaults and transmit FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_DBIT       = 8;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_SB_TICK    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int clog2_min1(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Synchronous FIFO with registered full/empty flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          w_push;
   logic          w_pop;

   // A pop frees a slot on the same edge, so a push while full still lands.
   assign w_pop  = pop_i && !empty_q;
   assign w_push = push_i && (!full_q || w_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      full_d   = full_q;
      empty_d  = empty_q;
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push && !w_pop) begin
         empty_d = 1'b0;
         full_d  = (wr_ptr_d == rd_ptr_q);
      end else if (w_pop && !w_push) begin
         full_d  = 1'b0;
         empty_d = (rd_ptr_d == wr_ptr_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_path.sv
// ============================================================================
// Module : uart_tx_path
// Brief  : UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_path
   import uart_pkg::*;
#(
   parameter int DBIT       = UART_DBIT,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int SB_TICK    = UART_SB_TICK,
   parameter int DVSR       = 1,
   parameter int FIFO_AW    = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [DBIT-1:0] w_data,
   input  logic            wr_uart,
   output logic            tx,
   output logic            tx_full,
   output logic            tx_empty,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int SCNT_W = clog2_min1((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
   localparam int NCNT_W = clog2_min1(DBIT);
   localparam int TCNT_W = clog2_min1(DVSR);

   localparam logic [SCNT_W-1:0] OS_LAST   = SCNT_W'(OVERSAMPLE - 1);
   localparam logic [SCNT_W-1:0] STOP_LAST = SCNT_W'(SB_TICK - 1);
   localparam logic [NCNT_W-1:0] BIT_LAST  = NCNT_W'(DBIT - 1);
   localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(DVSR - 1);

   tx_state_t         state_q, state_d;
   logic [SCNT_W-1:0] s_cnt_q, s_cnt_d;
   logic [NCNT_W-1:0] n_cnt_q, n_cnt_d;
   logic [TCNT_W-1:0] tick_q, tick_d;
   logic [DBIT-1:0]   b_q, b_d;
   logic              tx_q, tx_d;

   logic              w_s_tick;
   logic              w_pop;
   logic              w_fifo_empty;
   logic [DBIT-1:0]   w_fifo_rdata;
   logic [DBIT-1:0]   w_b_shift;

   uart_tx_fifo #(
      .DW (DBIT),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (wr_uart),
      .pop_i   (w_pop),
      .wdata_i (w_data),
      .rdata_o (w_fifo_rdata),
      .full_o  (tx_full),
      .empty_o (w_fifo_empty)
   );

   // Divider is held at zero while idle so every frame starts phase-aligned.
   assign w_s_tick = (state_q != IDLE) && (tick_q == TICK_LAST);

   always_comb begin
      tick_d = tick_q;
      if (state_q == IDLE || w_s_tick) tick_d = '0;
      else                             tick_d = tick_q + 1'b1;
   end

   assign w_b_shift = b_q >> 1;

   always_comb begin
      state_d      = state_q;
      s_cnt_d      = s_cnt_q;
      n_cnt_d      = n_cnt_q;
      b_d          = b_q;
      tx_d         = tx_q;
      w_pop        = 1'b0;
      tx_done_tick = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!w_fifo_empty) begin
               w_pop   = 1'b1;
               b_d     = w_fifo_rdata;
               s_cnt_d = '0;
               n_cnt_d = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (w_s_tick) begin
               if (s_cnt_q == OS_LAST) begin
                  s_cnt_d = '0;
                  state_d = DATA;
                  tx_d    = b_q[0];
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (w_s_tick) begin
               if (s_cnt_q == OS_LAST) begin
                  s_cnt_d = '0;
                  b_d     = w_b_shift;
                  if (n_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end else begin
                     n_cnt_d = n_cnt_q + 1'b1;
                     tx_d    = w_b_shift[0];
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (w_s_tick) begin
               if (s_cnt_q == STOP_LAST) begin
                  tx_done_tick = 1'b1;
                  s_cnt_d      = '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (!w_fifo_empty) begin
                     w_pop   = 1'b1;
                     b_d     = w_fifo_rdata;
                     n_cnt_d = '0;
                     state_d = START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         tick_q  <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         tick_q  <= tick_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign tx_empty = w_fifo_empty;
   assign tx_busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_path.sv
// ============================================================================
// Module : tb_uart_tx_path
// Brief  : Directed self-checking bench for uart_tx_path with a serial decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_path;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_uart = 1'b0;
   logic [7:0] w_data = 8'h00;
   logic       tx, tx_full, tx_empty, tx_busy, tx_done_tick;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int frame_err = 0;
   logic [7:0] rx_q[$];
   int fall_q[$];
   int done_q[$];

   uart_tx_path #(
      .DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .DVSR(1), .FIFO_AW(2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .w_data       (w_data),
      .wr_uart      (wr_uart),
      .tx           (tx),
      .tx_full      (tx_full),
      .tx_empty     (tx_empty),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (tx_done_tick === 1'b1) begin
         done_cnt++;
         done_q.push_back(cyc);
      end
   end

   // Serial receiver: frame clock k=1 is the first sample with tx low.
   initial begin : rx_model
      logic [7:0] sh;
      bit ab;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && tx === 1'b0) begin
            fall_q.push_back(cyc);
            sh = 8'h00;
            ab = 1'b0;
            for (int k = 2; k <= 153; k++) begin
               @(negedge clk);
               if (reset_n !== 1'b1) ab = 1'b1;
               if (k == 9 && tx !== 1'b0 && !ab) frame_err++;
               if (k >= 25 && k <= 137 && ((k - 25) % 16) == 0) sh[(k - 25) / 16] = tx;
            end
            if (!ab) begin
               if (tx !== 1'b1) frame_err++;
               rx_q.push_back(sh);
            end
         end
      end
   end

   function automatic logic exp_tx(input logic [7:0] b, input int k);
      if (k <= 0)   return 1'b1;
      if (k <= 16)  return 1'b0;
      if (k <= 144) return b[(k - 17) / 16];
      return 1'b1;
   endfunction

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int i = 0;
      while (rx_q.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int i = 0;
      while (!(tx_busy === 1'b0 && tx_empty === 1'b1) && i < budget) begin
         @(negedge clk);
         i++;
      end
      repeat (20) @(negedge clk);
      ok = (tx_busy === 1'b0 && tx_empty === 1'b1);
   endtask

   task automatic clear_queues();
      rx_q.delete();
      fall_q.delete();
      done_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({tx, tx_full, tx_empty, tx_busy, tx_done_tick} !== 5'b10100) begin
         bad++;
         $display("FAIL reset_hold: got tx/full/empty/busy/done=%b required 10100",
                  {tx, tx_full, tx_empty, tx_busy, tx_done_tick});
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({tx, tx_full, tx_empty, tx_busy, tx_done_tick} !== 5'b10100) begin
         bad++;
         $display("FAIL reset_release: got tx/full/empty/busy/done=%b required 10100",
                  {tx, tx_full, tx_empty, tx_busy, tx_done_tick});
      end
   endtask

   task automatic test_single_frame();
      int d0;
      bit ok;
      clear_queues();
      d0 = done_cnt;
      @(negedge clk);
      w_data = 8'hCD;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      total++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b0) begin
         bad++;
         $display("FAIL latency_k0: got tx=%b busy=%b empty=%b required 1 0 0", tx, tx_busy, tx_empty);
      end
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk);
         total++;
         if (tx !== exp_tx(8'hCD, k) || tx_done_tick !== (k == 160) || tx_busy !== (k <= 160)) begin
            bad++;
            $display("FAIL frame_cd clk %0d: got tx=%b done=%b busy=%b required %b %b %b", k, tx,
                     tx_done_tick, tx_busy, exp_tx(8'hCD, k), (k == 160), (k <= 160));
         end
      end
      wait_frames(1, 50, ok);
      total++;
      if (!ok || rx_q[0] !== 8'hCD || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL frame_cd_decode: got frames=%0d byte=%h done=%0d required 1 cd 1",
                  rx_q.size(), ok ? rx_q[0] : 8'hxx, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      bit ok;
      clear_queues();
      d0 = done_cnt;
      @(negedge clk);
      w_data = 8'h55;
      wr_uart = 1'b1;
      @(negedge clk);
      w_data = 8'hA3;
      @(negedge clk);
      wr_uart = 1'b0;
      wait_frames(2, 500, ok);
      total++;
      if (!ok || rx_q[0] !== 8'h55 || rx_q[1] !== 8'hA3) begin
         bad++;
         $display("FAIL b2b_data: got frames=%0d required 2 (55,a3)", rx_q.size());
      end
      wait_idle(300, ok);
      total++;
      if (!ok || done_cnt - d0 != 2) begin
         bad++;
         $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0);
      end
      total++;
      if (fall_q.size() != 2 || done_q.size() != 2 || fall_q[1] != done_q[0] + 1) begin
         bad++;
         $display("FAIL b2b_gap: got falls=%0d dones=%0d second_fall=%0d required first_done+1=%0d",
                  fall_q.size(), done_q.size(), (fall_q.size() > 1) ? fall_q[1] : -1,
                  (done_q.size() > 0) ? done_q[0] + 1 : -1);
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      int d0;
      bit ok;
      clear_queues();
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         w_data = vals[i];
         wr_uart = 1'b1;
      end
      @(negedge clk);
      wr_uart = 1'b0;
      total++;
      if (tx_full !== 1'b1) begin
         bad++;
         $display("FAIL full_flag: got %b required 1", tx_full);
      end
      wait_frames(5, 1000, ok);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (!ok || rx_q[i] !== vals[i]) begin
            bad++;
            $display("FAIL full_order[%0d]: got %h required %h", i, ok ? rx_q[i] : 8'hxx, vals[i]);
         end
      end
      wait_idle(400, ok);
      repeat (200) @(negedge clk);
      total++;
      if (rx_q.size() != 5 || done_cnt - d0 != 5 || tx_empty !== 1'b1 || tx_full !== 1'b0) begin
         bad++;
         $display("FAIL full_drop: got frames=%0d done=%0d empty=%b full=%b required 5 5 1 0",
                  rx_q.size(), done_cnt - d0, tx_empty, tx_full);
      end
   endtask

   task automatic test_reset_mid_frame();
      int hi_viol = 0;
      clear_queues();
      @(negedge clk);
      w_data = 8'hF0;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      @(negedge clk);
      w_data = 8'h11;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      repeat (57) @(negedge clk);
      total++;
      if (tx_busy !== 1'b1 || tx_empty !== 1'b0) begin
         bad++;
         $display("FAIL rst_pre: got busy=%b empty=%b required 1 0", tx_busy, tx_empty);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({tx, tx_full, tx_empty, tx_busy, tx_done_tick} !== 5'b10100) begin
         bad++;
         $display("FAIL rst_async: got tx/full/empty/busy/done=%b required 10100",
                  {tx, tx_full, tx_empty, tx_busy, tx_done_tick});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) hi_viol++;
      end
      total++;
      if (hi_viol != 0 || rx_q.size() != 0 || tx_empty !== 1'b1) begin
         bad++;
         $display("FAIL rst_no_resume: got activity=%0d frames=%0d empty=%b required 0 0 1",
                  hi_viol, rx_q.size(), tx_empty);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] vals [3] = '{8'hCD, 8'h00, 8'hFF};
      int fe0;
      bit ok;
      clear_queues();
      fe0 = frame_err;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         w_data = vals[i];
         wr_uart = 1'b1;
      end
      @(negedge clk);
      wr_uart = 1'b0;
      wait_frames(3, 700, ok);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (!ok || rx_q[i] !== vals[i]) begin
            bad++;
            $display("FAIL loop[%0d]: got %h required %h", i, ok ? rx_q[i] : 8'hxx, vals[i]);
         end
      end
      wait_idle(300, ok);
      total++;
      if (frame_err != fe0) begin
         bad++;
         $display("FAIL loop_framing: got %0d errors required 0", frame_err - fe0);
      end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] vals [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h96};
      int i;
      bit ok;
      clear_queues();
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         w_data = vals[j];
         wr_uart = 1'b1;
      end
      @(negedge clk);
      wr_uart = 1'b0;
      i = 0;
      while (tx_done_tick !== 1'b1 && i < 300) begin
         @(negedge clk);
         i++;
      end
      total++;
      if (tx_done_tick !== 1'b1 || tx_full !== 1'b1) begin
         bad++;
         $display("FAIL pp_pre: got done=%b full=%b required 1 1", tx_done_tick, tx_full);
      end
      w_data = vals[5];
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
      total++;
      if (tx_full !== 1'b1) begin
         bad++;
         $display("FAIL pp_full_stays: got %b required 1", tx_full);
      end
      wait_frames(6, 1200, ok);
      for (int j = 0; j < 6; j++) begin
         total++;
         if (!ok || rx_q[j] !== vals[j]) begin
            bad++;
            $display("FAIL pp_order[%0d]: got %h required %h", j, ok ? rx_q[j] : 8'hxx, vals[j]);
         end
      end
      wait_idle(300, ok);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      test_loopback();
      test_push_pop_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
